// File: rtl/rst_seq_gen.sv
// Reset sequencer: asserts NCH active-high reset channels together on power-on,
// on a run of trigger bytes from the UART, or on a software request, then releases
// them one after another with a fixed stagger so downstream blocks wake in order.
module rst_seq_gen #(
  parameter int          PULSE_LEN   = 16,
  parameter int          NCH         = 3,
  parameter int          STAGGER     = 4,
  parameter logic [7:0]  TRIG_CODE   = 8'h1b,
  parameter int          TRIG_COUNT  = 1,
  parameter int          TRIG_WINDOW = 1024
) (
  input  logic           clk,
  input  logic           resetq,
  input  logic           rx_data_rdy,
  input  logic [7:0]     rx_data,
  input  logic           sw_rst,
  input  logic           hold,
  output logic [NCH-1:0] rst,
  output logic           busy,
  output logic [1:0]     rst_cause
);

  // Count value at which the last channel lets go.
  localparam int LAST   = PULSE_LEN + STAGGER * (NCH - 1);
  localparam int CW     = $clog2(LAST + 1);
  localparam int MW     = $clog2(TRIG_COUNT + 1);
  localparam int WW     = $clog2(TRIG_WINDOW + 1);
  // With one channel or no stagger there is nothing to release in steps.
  localparam bit DIRECT = (NCH == 1) || (STAGGER == 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  logic [1:0]     sync_r;
  state_t         state_r;
  logic [CW-1:0]  cnt_r;
  logic [MW-1:0]  mc_r;
  logic [WW-1:0]  wt_r;
  logic [NCH-1:0] rst_r;
  logic           busy_r;
  logic [1:0]     cause_r;

  logic           byte_trig_s;
  logic           start_s;
  logic [MW-1:0]  mc_inc_s;
  logic [MW-1:0]  mc_nx_s;
  logic [WW-1:0]  wt_inc_s;
  logic [WW-1:0]  wt_nx_s;
  state_t         state_nx_s;
  logic [CW-1:0]  cnt_nx_s;
  logic [CW-1:0]  cnt_inc_s;
  logic [NCH-1:0] rst_nx_s;

  // Two-flop synchronizer on the release of the asynchronous reset.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], 1'b1};
    end
  end

  // Trigger-byte matcher: counts consecutive trigger bytes that arrive within the window.
  always_comb begin
    mc_inc_s    = mc_r + MW'(1'b1);
    byte_trig_s = 1'b0;
    if (wt_r == WW'(TRIG_WINDOW)) begin
      wt_inc_s = wt_r;
    end else begin
      wt_inc_s = wt_r + WW'(1'b1);
    end
    mc_nx_s = mc_r;
    wt_nx_s = wt_inc_s;
    if (rx_data_rdy) begin
      if (rx_data == TRIG_CODE) begin
        wt_nx_s = {WW{1'b0}};
        if (mc_inc_s == MW'(TRIG_COUNT)) begin
          byte_trig_s = 1'b1;
          mc_nx_s     = {MW{1'b0}};
        end else begin
          mc_nx_s = mc_inc_s;
        end
      end else begin
        mc_nx_s = {MW{1'b0}};
      end
    end else begin
      if (wt_inc_s == WW'(TRIG_WINDOW)) begin
        mc_nx_s = {MW{1'b0}};
      end else begin
        mc_nx_s = mc_r;
      end
    end
  end

  // Matcher state registers.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      mc_r <= {MW{1'b0}};
      wt_r <= {WW{1'b0}};
    end else begin
      mc_r <= mc_nx_s;
      wt_r <= wt_nx_s;
    end
  end

  // Sequencer next state; a new start always wins and restarts the whole pulse.
  always_comb begin
    start_s    = byte_trig_s | sw_rst;
    cnt_inc_s  = cnt_r + CW'(1'b1);
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    if (start_s) begin
      state_nx_s = ST_ASSERT;
      cnt_nx_s   = {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = {CW{1'b0}};
        end
        ST_ASSERT: begin
          if (!sync_r[1] || hold) begin
            state_nx_s = ST_ASSERT;
            cnt_nx_s   = {CW{1'b0}};
          end else if (cnt_r == CW'(PULSE_LEN - 1)) begin
            if (DIRECT) begin
              state_nx_s = ST_IDLE;
              cnt_nx_s   = {CW{1'b0}};
            end else begin
              state_nx_s = ST_RELEASE;
              cnt_nx_s   = cnt_inc_s;
            end
          end else begin
            state_nx_s = ST_ASSERT;
            cnt_nx_s   = cnt_inc_s;
          end
        end
        ST_RELEASE: begin
          if (cnt_inc_s == CW'(LAST)) begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = {CW{1'b0}};
          end else begin
            state_nx_s = ST_RELEASE;
            cnt_nx_s   = cnt_inc_s;
          end
        end
        default: begin
          state_nx_s = ST_ASSERT;
          cnt_nx_s   = {CW{1'b0}};
        end
      endcase
    end
  end

  // Channel i stays asserted until the count reaches PULSE_LEN + i*STAGGER.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign rst_nx_s[i] = (state_nx_s != ST_IDLE) && (cnt_nx_s < CW'(PULSE_LEN + i * STAGGER));
  end

  // FSM with registered outputs; the cause is latched whenever a sequence starts.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_r <= ST_ASSERT;
      cnt_r   <= {CW{1'b0}};
      rst_r   <= {NCH{1'b1}};
      busy_r  <= 1'b1;
      cause_r <= 2'b00;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      rst_r   <= rst_nx_s;
      busy_r  <= (state_nx_s != ST_IDLE);
      if (start_s) begin
        cause_r <= sw_rst ? 2'b10 : 2'b01;
      end else begin
        cause_r <= cause_r;
      end
    end
  end

  assign rst       = rst_r;
  assign busy      = busy_r;
  assign rst_cause = cause_r;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: two instances (single-byte trigger, and two-byte trigger
// with a short window) share the stimulus and are compared every cycle against a
// timeline model: each instance remembers the edge its current pulse started on,
// and every output follows from the elapsed cycle count since then.
module tb_rst_seq_gen;

  localparam int P    = 16;
  localparam int N    = 3;
  localparam int S    = 4;
  localparam int LAST = P + S * (N - 1);

  logic         clk = 1'b0;
  logic         resetq;
  logic         rx_data_rdy;
  logic [7:0]   rx_data;
  logic         sw_rst;
  logic         hold;
  logic [N-1:0] rst_a, rst_b;
  logic         busy_a, busy_b;
  logic [1:0]   cause_a, cause_b;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit in_reset    = 1'b1;
  int por_left    = 0;
  int tstart[2];
  int cause[2];
  int mcnt[2];
  int mlast[2];
  int tc[2] = '{1, 2};
  int tw[2] = '{1024, 8};

  always #5 clk = ~clk;

  rst_seq_gen #(.PULSE_LEN(P), .NCH(N), .STAGGER(S), .TRIG_CODE(8'h1b),
                .TRIG_COUNT(1), .TRIG_WINDOW(1024)) u_a (
    .clk(clk), .resetq(resetq), .rx_data_rdy(rx_data_rdy), .rx_data(rx_data),
    .sw_rst(sw_rst), .hold(hold), .rst(rst_a), .busy(busy_a), .rst_cause(cause_a));

  rst_seq_gen #(.PULSE_LEN(P), .NCH(N), .STAGGER(S), .TRIG_CODE(8'h1b),
                .TRIG_COUNT(2), .TRIG_WINDOW(8)) u_b (
    .clk(clk), .resetq(resetq), .rx_data_rdy(rx_data_rdy), .rx_data(rx_data),
    .sw_rst(sw_rst), .hold(hold), .rst(rst_b), .busy(busy_b), .rst_cause(cause_b));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_inst(input string nm, input int k, input logic [N-1:0] r,
                            input logic b, input logic [1:0] c);
    logic [N-1:0] er;
    logic         eb;
    int           ec;
    int           e;
    if (in_reset) begin
      er = {N{1'b1}};
      eb = 1'b1;
      ec = 0;
    end else begin
      e = cyc - tstart[k];
      for (int i = 0; i < N; i++) er[i] = (e < P + i * S);
      eb = (e < LAST);
      ec = cause[k];
    end
    check_eq({nm, ".rst"}, 32'(r), 32'(er));
    check_eq({nm, ".busy"}, 32'(b), 32'(eb));
    check_eq({nm, ".cause"}, 32'(c), 32'(ec));
  endtask

  task automatic check_all();
    check_inst("a", 0, rst_a, busy_a, cause_a);
    check_inst("b", 1, rst_b, busy_b, cause_b);
  endtask

  // Apply the rules of one clock edge to the timeline of each instance.
  task automatic model_edge();
    bit fire;
    if (!in_reset) begin
      for (int k = 0; k < 2; k++) begin
        fire = 1'b0;
        if (rx_data_rdy) begin
          if (rx_data == 8'h1b) begin
            if (mcnt[k] > 0 && (cyc - mlast[k]) > tw[k]) mcnt[k] = 0;
            mcnt[k]++;
            mlast[k] = cyc;
            if (mcnt[k] == tc[k]) begin
              fire    = 1'b1;
              mcnt[k] = 0;
            end
          end else begin
            mcnt[k] = 0;
          end
        end
        if (fire || sw_rst) begin
          tstart[k] = cyc;
          cause[k]  = sw_rst ? 2 : 1;
        end else if (por_left > 0) begin
          tstart[k] = cyc;
        end else if (hold && ((cyc - 1) - tstart[k]) < P) begin
          tstart[k] = cyc;
        end
      end
      if (por_left > 0) por_left--;
    end
  endtask

  task automatic tick(input bit rdy, input logic [7:0] d, input bit sw, input bit hd);
    rx_data_rdy = rdy;
    rx_data     = d;
    sw_rst      = sw;
    hold        = hd;
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic release_reset();
    resetq   = 1'b1;
    in_reset = 1'b0;
    por_left = 2;
    for (int k = 0; k < 2; k++) begin
      tstart[k] = cyc;
      cause[k]  = 0;
      mcnt[k]   = 0;
      mlast[k]  = cyc;
    end
  endtask

  function automatic bit in_release(input int k);
    int e;
    e = cyc - tstart[k];
    return (e >= P) && (e < LAST);
  endfunction

  initial begin
    resetq      = 1'b0;
    rx_data_rdy = 1'b0;
    rx_data     = 8'h00;
    sw_rst      = 1'b0;
    hold        = 1'b0;
    in_reset    = 1'b1;

    // Power-on reset held for five cycles.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_all();
    end
    release_reset();
    idle(32);

    // Single trigger byte.
    tick(1'b1, 8'h1b, 1'b0, 1'b0);
    idle(30);

    // Two trigger bytes 8 cycles apart: the two-byte instance fires.
    tick(1'b1, 8'h1b, 1'b0, 1'b0);
    idle(7);
    tick(1'b1, 8'h1b, 1'b0, 1'b0);
    idle(30);

    // Trigger, other byte, trigger: the two-byte instance must not fire.
    tick(1'b1, 8'h1b, 1'b0, 1'b0);
    tick(1'b1, 8'h41, 1'b0, 1'b0);
    tick(1'b1, 8'h1b, 1'b0, 1'b0);
    idle(30);

    // Trigger bytes 9 cycles apart: window expires, no fire.
    tick(1'b1, 8'h1b, 1'b0, 1'b0);
    idle(8);
    tick(1'b1, 8'h1b, 1'b0, 1'b0);
    idle(30);

    // Software retrigger while channel 0 is already released.
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    idle(17);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    idle(30);

    // Byte trigger and sw_rst on the same edge, then hold for 30 cycles.
    tick(1'b1, 8'h1b, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) tick(1'b0, 8'h00, 1'b0, 1'b1);
    idle(30);

    // Hold in IDLE does nothing.
    for (int i = 0; i < 5; i++) tick(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2);

    // Asynchronous reset in the middle of RELEASE.
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    idle(19);
    resetq   = 1'b0;
    in_reset = 1'b1;
    #1;
    check_all();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_all();
    end
    release_reset();
    idle(30);

    // Randomized traffic; hold is only raised outside RELEASE.
    for (int i = 0; i < 1500; i++) begin
      bit         rdy;
      bit         sw;
      bit         hd;
      logic [7:0] d;
      rdy = ($urandom_range(0, 2) == 0);
      d   = ($urandom_range(0, 1) == 1) ? 8'h1b : 8'($urandom_range(0, 255));
      sw  = ($urandom_range(0, 59) == 0);
      hd  = !in_release(0) && !in_release(1) && ($urandom_range(0, 7) == 0);
      tick(rdy, d, sw, hd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
